bnn_infer_seq: RTL and testbench

Top-level sequencer for the binary CNN inference datapath (18C5 -> P2 -> 60C5 -> P2 -> FC10 -> argmax). It arbitrates the shared kernel/offset write port against inference and tracks per-layer weight-load completeness. It gates the image handshake, issues one-cycle capture enables to the image memory, both pool pipeline registers and the argmax register, and owns the class output handshake. It replaces the fixed 3-cycle conv counter with a parameterised stage schedule.

---
 rtl/bnn_pkg.sv | 24 ++
 rtl/bnn_wload_track.sv | 75 +++++++
 rtl/bnn_infer_seq.sv | 112 +++++++++++
 tb/tb_bnn_infer_seq.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared types and constants for the binary CNN inference sequencer.
// Layer codes, sequencer states, default per-layer weight word counts.
package bnn_pkg;

  localparam int KADDR_W      = 11;
  localparam int L1_WORDS_DEF = 90;
  localparam int L2_WORDS_DEF = 1080;
  localparam int FC_WORDS_DEF = 10;

  typedef enum logic [1:0] {
    LYR_NONE = 2'd0,
    LYR_C1   = 2'd1,
    LYR_C2   = 2'd2,
    LYR_FC   = 2'd3
  } layer_t;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_WAIT_IMAGE,
    ST_RUN,
    ST_WAIT_OUT
  } seq_state_t;

endpackage

// File: rtl/bnn_wload_track.sv
// Weight-load tracker: range check, per-layer saturating write counters, deferred clear.
// Write strobe is combinational; err pulses one cycle after a rejected write; never stalls.
module bnn_wload_track
  import bnn_pkg::*;
#(
  parameter int L1_WORDS = L1_WORDS_DEF,
  parameter int L2_WORDS = L2_WORDS_DEF,
  parameter int FC_WORDS = FC_WORDS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_acc,
  input  logic [1:0]         layer,
  input  logic [KADDR_W-1:0] addr,
  input  logic               clear_req,
  input  logic               clear_defer,
  input  logic               clear_flush,
  output logic [1:0]         wr_en,
  output logic               err,
  output logic               weights_ready,
  output logic               clear_pending
);

  localparam logic [KADDR_W-1:0] L1_MAX = KADDR_W'(L1_WORDS);
  localparam logic [KADDR_W-1:0] L2_MAX = KADDR_W'(L2_WORDS);
  localparam logic [KADDR_W-1:0] FC_MAX = KADDR_W'(FC_WORDS);

  logic [KADDR_W-1:0] cnt1, cnt2, cntf;
  logic [KADDR_W-1:0] limit;
  logic               in_range;
  logic               clear_now;

  always_comb begin
    limit = '0;
    case (layer)
      LYR_C1:  limit = L1_MAX;
      LYR_C2:  limit = L2_MAX;
      LYR_FC:  limit = FC_MAX;
      default: limit = '0;
    endcase
  end

  // layer 0 has a zero limit, so it always falls out of range
  assign in_range      = addr < limit;
  assign wr_en         = (wr_acc && in_range) ? layer : 2'd0;
  assign weights_ready = (cnt1 == L1_MAX) && (cnt2 == L2_MAX) && (cntf == FC_MAX);

  // A clear raised while an inference is in flight waits for the result handshake.
  assign clear_now = clear_flush ? (clear_pending || clear_req)
                                 : (clear_req && !clear_defer);

  always_ff @(posedge clk) begin
    if (rst || clear_now) begin
      cnt1 <= '0;
      cnt2 <= '0;
      cntf <= '0;
    end else begin
      if (wr_en == LYR_C1 && cnt1 != L1_MAX) cnt1 <= cnt1 + KADDR_W'(1);
      if (wr_en == LYR_C2 && cnt2 != L2_MAX) cnt2 <= cnt2 + KADDR_W'(1);
      if (wr_en == LYR_FC && cntf != FC_MAX) cntf <= cntf + KADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err           <= 1'b0;
      clear_pending <= 1'b0;
    end else begin
      err <= wr_acc && !in_range;
      if (clear_now)                     clear_pending <= 1'b0;
      else if (clear_req && clear_defer) clear_pending <= 1'b1;
    end
  end

endmodule

// File: rtl/bnn_infer_seq.sv
// Inference sequencer: weight-port arbitration, image gating, stage enables, class handshake.
// Image to class valid takes 2+LAT_P1+LAT_P2 cycles; holds class valid until ready, stalls images meanwhile.
module bnn_infer_seq
  import bnn_pkg::*;
#(
  parameter int L1_WORDS = L1_WORDS_DEF,
  parameter int L2_WORDS = L2_WORDS_DEF,
  parameter int FC_WORDS = FC_WORDS_DEF,
  parameter int LAT_P1   = 1,
  parameter int LAT_P2   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               image_in_valid,
  output logic               image_in_ready,
  output logic               image_capture,
  input  logic               kernel_in_valid,
  input  logic [1:0]         kernel_layer,
  input  logic [KADDR_W-1:0] kernel_addr,
  output logic               kernel_in_ready,
  output logic [1:0]         kernel_wr_en,
  output logic               kernel_err,
  input  logic               weights_clear,
  output logic               weights_ready,
  output logic [2:0]         stage_en,
  input  logic               class_out_ready,
  output logic               class_out_valid,
  output logic               busy
);

  localparam logic [4:0] P1_AT = 5'(LAT_P1);
  localparam logic [4:0] P2_AT = 5'(LAT_P1 + LAT_P2);

  seq_state_t state;
  logic [4:0] stage_cnt;
  logic [4:0] stage_nxt;
  logic       wr_acc;
  logic       img_hs;
  logic       out_hs;
  logic       clear_pending;

  assign kernel_in_ready = (state == ST_LOAD) || (state == ST_WAIT_IMAGE);
  assign wr_acc          = kernel_in_valid && kernel_in_ready;
  // a weight write in the same cycle wins over the image
  assign image_in_ready  = (state == ST_WAIT_IMAGE) && weights_ready && !kernel_in_valid;
  assign img_hs          = image_in_valid && image_in_ready;
  assign image_capture   = img_hs;
  assign out_hs          = class_out_valid && class_out_ready;
  assign busy            = (state == ST_RUN) || (state == ST_WAIT_OUT);
  assign stage_nxt       = stage_cnt + 5'd1;

  bnn_wload_track #(
    .L1_WORDS(L1_WORDS),
    .L2_WORDS(L2_WORDS),
    .FC_WORDS(FC_WORDS)
  ) u_wload (
    .clk          (clk),
    .rst          (rst),
    .wr_acc       (wr_acc),
    .layer        (kernel_layer),
    .addr         (kernel_addr),
    .clear_req    (weights_clear),
    .clear_defer  (busy || img_hs),
    .clear_flush  (out_hs),
    .wr_en        (kernel_wr_en),
    .err          (kernel_err),
    .weights_ready(weights_ready),
    .clear_pending(clear_pending)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_LOAD;
      stage_cnt       <= '0;
      stage_en        <= '0;
      class_out_valid <= 1'b0;
    end else begin
      stage_en <= '0;
      case (state)
        ST_LOAD: begin
          if (weights_ready && !weights_clear) state <= ST_WAIT_IMAGE;
        end
        ST_WAIT_IMAGE: begin
          if (img_hs) begin
            state     <= ST_RUN;
            stage_cnt <= '0;
            stage_en  <= 3'b001;
          end else if (weights_clear) begin
            state <= ST_LOAD;
          end
        end
        ST_RUN: begin
          stage_cnt <= stage_nxt;
          if (stage_nxt == P1_AT)      stage_en <= 3'b010;
          else if (stage_nxt == P2_AT) stage_en <= 3'b100;
          if (stage_cnt == P2_AT) begin
            state           <= ST_WAIT_OUT;
            class_out_valid <= 1'b1;
          end
        end
        ST_WAIT_OUT: begin
          if (class_out_ready) begin
            class_out_valid <= 1'b0;
            state <= (clear_pending || weights_clear) ? ST_LOAD : ST_WAIT_IMAGE;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_infer_seq.sv
// Two sequencers (default latency and LAT_P1=3/LAT_P2=2) share the weight bus and clear;
// expected stage/valid/err events are queued by stimulus and matched by a negedge monitor.
`timescale 1ns/1ps
module tb_bnn_infer_seq;
  import bnn_pkg::*;

  localparam int NI    = 2;
  localparam int LP1_B = 3;
  localparam int LP2_B = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        kernel_in_valid;
  logic [1:0]  kernel_layer;
  logic [10:0] kernel_addr;
  logic        weights_clear;
  logic        img_vld [NI];
  logic        img_rdy [NI];
  logic        img_cap [NI];
  logic        kin_rdy [NI];
  logic [1:0]  kwr_en  [NI];
  logic        kerr    [NI];
  logic        wrdy    [NI];
  logic [2:0]  stg     [NI];
  logic        crdy    [NI];
  logic        cvld    [NI];
  logic        busy    [NI];
  logic        prev_v  [NI] = '{1'b0, 1'b0};

  bnn_infer_seq dut0 (
    .clk(clk), .rst(rst),
    .image_in_valid(img_vld[0]), .image_in_ready(img_rdy[0]), .image_capture(img_cap[0]),
    .kernel_in_valid(kernel_in_valid), .kernel_layer(kernel_layer), .kernel_addr(kernel_addr),
    .kernel_in_ready(kin_rdy[0]), .kernel_wr_en(kwr_en[0]), .kernel_err(kerr[0]),
    .weights_clear(weights_clear), .weights_ready(wrdy[0]), .stage_en(stg[0]),
    .class_out_ready(crdy[0]), .class_out_valid(cvld[0]), .busy(busy[0])
  );

  bnn_infer_seq #(.LAT_P1(LP1_B), .LAT_P2(LP2_B)) dut1 (
    .clk(clk), .rst(rst),
    .image_in_valid(img_vld[1]), .image_in_ready(img_rdy[1]), .image_capture(img_cap[1]),
    .kernel_in_valid(kernel_in_valid), .kernel_layer(kernel_layer), .kernel_addr(kernel_addr),
    .kernel_in_ready(kin_rdy[1]), .kernel_wr_en(kwr_en[1]), .kernel_err(kerr[1]),
    .weights_clear(weights_clear), .weights_ready(wrdy[1]), .stage_en(stg[1]),
    .class_out_ready(crdy[1]), .class_out_valid(cvld[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int inst; int kind; int at; } exp_t;
  exp_t  exp_q [$];
  string kn [5] = '{"stage_pool1", "stage_pool2", "stage_argmax", "class_valid", "kernel_err"};
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic int p1(int i); return (i == 0) ? 1 : LP1_B; endfunction
  function automatic int p2(int i); return (i == 0) ? 1 : LP2_B; endfunction
  function automatic int words(int l);
    return (l == 1) ? L1_WORDS_DEF : (l == 2) ? L2_WORDS_DEF : (l == 3) ? FC_WORDS_DEF : 0;
  endfunction

  task automatic check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(int i, int k, int at);
    exp_q.push_back('{i, k, at});
  endtask

  task automatic match(int i, int k);
    int idx;
    idx = -1;
    foreach (exp_q[j]) if (idx < 0 && exp_q[j].inst == i && exp_q[j].kind == k) idx = j;
    if (idx < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_%s_u%0d: got event at cycle %0d, want none", kn[k], i, cyc);
    end else begin
      check($sformatf("%s_u%0d_cycle", kn[k], i), cyc, exp_q[idx].at);
      exp_q.delete(idx);
    end
  endtask

  task automatic purge(int i);
    for (int j = exp_q.size() - 1; j >= 0; j--)
      if (exp_q[j].inst == i && exp_q[j].kind < 4) exp_q.delete(j);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (stg[i] != 3'b000) check($sformatf("stage_onehot_u%0d", i), $countones(stg[i]), 1);
      for (int k = 0; k < 3; k++) if (stg[i][k] === 1'b1) match(i, k);
      if (cvld[i] === 1'b1 && prev_v[i] !== 1'b1) match(i, 3);
      if (kerr[i] === 1'b1) match(i, 4);
      prev_v[i] <= cvld[i];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_weights();
    int rem [4];
    int total, r, pick;
    rem   = '{0, L1_WORDS_DEF, L2_WORDS_DEF, FC_WORDS_DEF};
    total = L1_WORDS_DEF + L2_WORDS_DEF + FC_WORDS_DEF;
    while (total > 0) begin
      r = int'($urandom_range(0, 15));
      kernel_in_valid = 1'b1;
      if (r == 0) begin
        kernel_in_valid = 1'b0;
        @(negedge clk);
      end else if (r == 1) begin
        case ($urandom_range(0, 2))
          0: begin kernel_layer = 2'd0; kernel_addr = 11'($urandom_range(0, 100)); end
          1: begin kernel_layer = 2'd2; kernel_addr = 11'(L2_WORDS_DEF); end
          default: begin
            pick = ($urandom_range(0, 1) == 0) ? 1 : 3;
            kernel_layer = 2'(pick);
            kernel_addr  = 11'(words(pick) + int'($urandom_range(0, 20)));
          end
        endcase
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
          check($sformatf("bad_wr_en_u%0d", i), kwr_en[i], 0);
          expect_ev(i, 4, cyc + 1);
        end
      end else begin
        do pick = int'($urandom_range(1, 3)); while (rem[pick] == 0);
        kernel_layer = 2'(pick);
        kernel_addr  = 11'($urandom_range(0, words(pick) - 1));
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
          check($sformatf("wr_en_u%0d", i), kwr_en[i], pick);
          if (total == 1) begin
            check($sformatf("wready_before_last_u%0d", i), wrdy[i], 0);
            check($sformatf("img_ready_loading_u%0d", i), img_rdy[i], 0);
          end
        end
        rem[pick]--;
        total--;
      end
      step();
    end
    kernel_in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("wready_after_last_u%0d", i), wrdy[i], 1);
      check($sformatf("img_ready_still_load_u%0d", i), img_rdy[i], 0);
    end
    step();
    @(negedge clk);
    for (int i = 0; i < NI; i++) check($sformatf("img_ready_wait_image_u%0d", i), img_rdy[i], 1);
    step();
  endtask

  task automatic accept_image(int i);
    int t;
    @(negedge clk);
    check($sformatf("image_capture_u%0d", i), img_cap[i], 1);
    t = cyc;
    expect_ev(i, 0, t + 1);
    expect_ev(i, 1, t + 1 + p1(i));
    expect_ev(i, 2, t + 1 + p1(i) + p2(i));
    expect_ev(i, 3, t + 2 + p1(i) + p2(i));
    step();
    img_vld[i] = 1'b0;
  endtask

  // rdy_delay < 0 holds class_out_ready high and returns one cycle after the handshake
  task automatic run_image(int i, bit collide, int rdy_delay, bit clr, bit kwr);
    int  pick;
    bit  got;
    crdy[i]    = (rdy_delay < 0);
    img_vld[i] = 1'b1;
    if (collide) begin
      kernel_in_valid = 1'b1;
      kernel_layer    = 2'd3;
      kernel_addr     = 11'($urandom_range(0, FC_WORDS_DEF - 1));
      @(negedge clk);
      check($sformatf("collide_capture_u%0d", i), img_cap[i], 0);
      check($sformatf("collide_wr_en_u%0d", i), kwr_en[i], 3);
      step();
      kernel_in_valid = 1'b0;
    end
    accept_image(i);
    kernel_in_valid = kwr;
    pick = int'($urandom_range(1, 3));
    kernel_layer = 2'(pick);
    kernel_addr  = 11'($urandom_range(0, words(pick) - 1));
    @(negedge clk);
    check($sformatf("busy_run_u%0d", i), busy[i], 1);
    if (kwr) begin
      check($sformatf("kin_ready_run_u%0d", i), kin_rdy[i], 0);
      check($sformatf("wr_en_run_u%0d", i), kwr_en[i], 0);
    end
    step();
    kernel_in_valid = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (cvld[i]) begin got = 1'b1; break; end
      step();
    end
    if (!got) begin
      check($sformatf("class_valid_timeout_u%0d", i), 0, 1);
      return;
    end
    if (rdy_delay < 0) begin
      step();
      crdy[i] = 1'b0;
      return;
    end
    for (int d = 0; d < rdy_delay; d++) begin
      step();
      weights_clear = clr && (d == 0);
      @(negedge clk);
      check($sformatf("valid_held_u%0d", i), cvld[i], 1);
      check($sformatf("wready_held_u%0d", i), wrdy[i], 1);
    end
    step();
    weights_clear = 1'b0;
    crdy[i] = 1'b1;
    @(negedge clk);
    step();
    crdy[i] = 1'b0;
    @(negedge clk);
    check($sformatf("valid_drop_u%0d", i), cvld[i], 0);
    check($sformatf("busy_idle_u%0d", i), busy[i], 0);
    check($sformatf("wready_after_out_u%0d", i), wrdy[i], clr ? 0 : 1);
    check($sformatf("img_ready_after_out_u%0d", i), img_rdy[i], clr ? 0 : 1);
    check($sformatf("kin_ready_after_out_u%0d", i), kin_rdy[i], 1);
    if (clr) check($sformatf("wready_other_cleared_u%0d", 1 - i), wrdy[1 - i], 0);
    step();
  endtask

  task automatic reset_mid(int i);
    img_vld[i] = 1'b1;
    accept_image(i);
    step();
    rst = 1'b1;
    @(negedge clk);
    step();
    rst = 1'b0;
    purge(i);
    @(negedge clk);
    check($sformatf("rst_stage_u%0d", i), stg[i], 0);
    check($sformatf("rst_valid_u%0d", i), cvld[i], 0);
    check($sformatf("rst_busy_u%0d", i), busy[i], 0);
    check($sformatf("rst_wready_u%0d", i), wrdy[i], 0);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, want finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    kernel_in_valid = 1'b0;
    kernel_layer    = 2'd0;
    kernel_addr     = '0;
    weights_clear   = 1'b0;
    for (int i = 0; i < NI; i++) begin
      img_vld[i] = 1'b0;
      crdy[i]    = 1'b0;
    end
    repeat (3) step();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset_stage_u%0d", i), stg[i], 0);
      check($sformatf("reset_valid_u%0d", i), cvld[i], 0);
      check($sformatf("reset_busy_u%0d", i), busy[i], 0);
      check($sformatf("reset_wready_u%0d", i), wrdy[i], 0);
      check($sformatf("reset_err_u%0d", i), kerr[i], 0);
    end
    step();
    rst = 1'b0;

    load_weights();

    run_image(0, 1'b0, 0, 1'b0, 1'b1);
    run_image(1, 1'b0, 2, 1'b0, 1'b0);
    run_image(0, 1'b1, -1, 1'b0, 1'b0);
    run_image(0, 1'b0, -1, 1'b0, 1'b0);
    run_image(0, 1'b0, 1, 1'b0, 1'b0);
    run_image(1, 1'b0, -1, 1'b0, 1'b1);
    run_image(1, 1'b0, 0, 1'b0, 1'b0);
    for (int n = 0; n < 6; n++)
      run_image(int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 3)), 1'b0, ($urandom_range(0, 1) == 1));

    run_image(0, 1'b0, 5, 1'b1, 1'b0);

    load_weights();
    reset_mid(1);

    repeat (10) step();
    foreach (exp_q[j]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_%s_u%0d: got no event, want one at cycle %0d",
               kn[exp_q[j].kind], exp_q[j].inst, exp_q[j].at);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
